// File: rtl/class_score_accumulator.sv
// ---------------------------------------------------------------------------
// class_score_accumulator
//   Sums a stream of signed partial products into ten saturating class scores.
//   The sample is published on Num when the last beat arrives. Num is held
//   until NumAck. The next sample accumulates while the previous one is held.
//
// Ports
//   Clock          rising-edge clock
//   GlobalReset_n  asynchronous active-low reset
//   InValid/InReady/InClass/InProd/InLast  partial-product beat handshake
//   Num            packed scores, class k at Num[NUM_SIZE*k +: NUM_SIZE]
//   NumValid       Num holds an unacknowledged sample
//   NumAck         consumer has taken Num (only used while NumValid=1)
//   SatFlag        a clamp occurred in the published sample
//   ClassErr       sticky: a beat with InClass > 9 was accepted
// ---------------------------------------------------------------------------
module class_score_accumulator #(
    parameter int NUM_SIZE  = 26,
    parameter int PROD_SIZE = 16
) (
    input  logic                     Clock,
    input  logic                     GlobalReset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [3:0]               InClass,
    input  logic [PROD_SIZE-1:0]     InProd,
    input  logic                     InLast,
    output logic [NUM_SIZE*10-1:0]   Num,
    output logic                     NumValid,
    input  logic                     NumAck,
    output logic                     SatFlag,
    output logic                     ClassErr
);

    localparam int unsigned NCLASS = 10;

    typedef enum logic {
        ST_ACCUM,
        ST_WAIT
    } state_t;

    state_t                       state_q, state_d;
    logic signed [NUM_SIZE-1:0]   acc_q   [NCLASS];
    logic signed [NUM_SIZE-1:0]   acc_d   [NCLASS];
    logic signed [NUM_SIZE-1:0]   acc_upd [NCLASS];
    logic                         sat_q, sat_d, sat_upd;
    logic [NUM_SIZE*10-1:0]       num_q, num_d;
    logic                         num_valid_q, num_valid_d;
    logic                         sat_flag_q, sat_flag_d;
    logic                         class_err_q, class_err_d;

    logic [NUM_SIZE*10-1:0]       pack_upd, pack_q;
    logic [NUM_SIZE-1:0]          sel_acc;
    logic [NUM_SIZE:0]            prod_ext;
    logic [NUM_SIZE:0]            sum;
    logic                         overflow;
    logic [NUM_SIZE-1:0]          sat_val;
    logic                         accept;
    logic                         class_ok;
    logic                         out_free;

    // Ready is purely a state decode, held low while reset is asserted.
    assign InReady  = GlobalReset_n && (state_q == ST_ACCUM);
    assign accept   = InValid && InReady;
    assign class_ok = (InClass <= 4'd9);
    assign out_free = !num_valid_q || NumAck;

    assign prod_ext = {{(NUM_SIZE + 1 - PROD_SIZE){InProd[PROD_SIZE-1]}}, InProd};

    always_comb begin
        sel_acc = '0;
        for (int unsigned k = 0; k < NCLASS; k++) begin
            if (InClass == 4'(k)) sel_acc = acc_q[k];
        end
    end

    // One guard bit: the top two bits disagree exactly when the true sum is
    // outside the NUM_SIZE range. The guard bit gives the direction.
    assign sum      = {sel_acc[NUM_SIZE-1], sel_acc} + prod_ext;
    assign overflow = sum[NUM_SIZE] ^ sum[NUM_SIZE-1];
    assign sat_val  = !overflow      ? sum[NUM_SIZE-1:0] :
                      sum[NUM_SIZE]  ? {1'b1, {(NUM_SIZE-1){1'b0}}} :
                                       {1'b0, {(NUM_SIZE-1){1'b1}}};

    always_comb begin
        for (int unsigned k = 0; k < NCLASS; k++) begin
            acc_upd[k] = (accept && class_ok && (InClass == 4'(k))) ? sat_val : acc_q[k];
        end
        sat_upd = sat_q | (accept && class_ok && overflow);
    end

    always_comb begin
        pack_upd = '0;
        pack_q   = '0;
        for (int unsigned k = 0; k < NCLASS; k++) begin
            pack_upd[NUM_SIZE*k +: NUM_SIZE] = acc_upd[k];
            pack_q[NUM_SIZE*k +: NUM_SIZE]   = acc_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        num_d       = num_q;
        num_valid_d = num_valid_q;
        sat_flag_d  = sat_flag_q;
        class_err_d = class_err_q | (accept && !class_ok);

        unique case (state_q)
            ST_ACCUM: begin
                acc_d = acc_upd;
                sat_d = sat_upd;
                if (accept && InLast) begin
                    if (out_free) begin
                        num_d       = pack_upd;
                        num_valid_d = 1'b1;
                        sat_flag_d  = sat_upd;
                        for (int unsigned k = 0; k < NCLASS; k++) acc_d[k] = '0;
                        sat_d       = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (num_valid_q && NumAck) begin
                    num_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // NumValid is always set here, so NumAck alone means transfer.
                if (NumAck) begin
                    num_d       = pack_q;
                    sat_flag_d  = sat_q;
                    num_valid_d = 1'b1;
                    for (int unsigned k = 0; k < NCLASS; k++) acc_d[k] = '0;
                    sat_d       = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge Clock or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            state_q     <= ST_ACCUM;
            for (int unsigned k = 0; k < NCLASS; k++) acc_q[k] <= '0;
            sat_q       <= 1'b0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            class_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            sat_flag_q  <= sat_flag_d;
            class_err_q <= class_err_d;
        end
    end

    assign Num      = num_q;
    assign NumValid = num_valid_q;
    assign SatFlag  = sat_flag_q;
    assign ClassErr = class_err_q;

endmodule

// File: tb/tb_class_score_accumulator.sv
module tb_class_score_accumulator;

    localparam int NS = 26;
    localparam int PS = 16;

    logic            Clock = 1'b0;
    logic            GlobalReset_n;
    logic            InValid;
    logic            InReady;
    logic [3:0]      InClass;
    logic [PS-1:0]   InProd;
    logic            InLast;
    logic [NS*10-1:0] Num;
    logic            NumValid;
    logic            NumAck;
    logic            SatFlag;
    logic            ClassErr;

    class_score_accumulator #(.NUM_SIZE(NS), .PROD_SIZE(PS)) dut (
        .Clock(Clock), .GlobalReset_n(GlobalReset_n),
        .InValid(InValid), .InReady(InReady), .InClass(InClass),
        .InProd(InProd), .InLast(InLast), .Num(Num), .NumValid(NumValid),
        .NumAck(NumAck), .SatFlag(SatFlag), .ClassErr(ClassErr)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    localparam longint SMAX = (longint'(1) <<< (NS - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (NS - 1));

    // Reference model: the running sample, a sample parked behind a full
    // output, and what the consumer currently sees.
    longint m_run [10];
    bit     m_run_sat;
    bit     m_parked;
    longint m_pub [10];
    bit     m_pub_sat;
    bit     m_valid;
    bit     m_err;
    bit     m_in_reset;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint score(input int k);
        logic [NS-1:0] s;
        s = Num[NS*k +: NS];
        return longint'($signed(s));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 10; k++) begin
            m_run[k] = 0;
            m_pub[k] = 0;
        end
        m_run_sat = 0; m_parked = 0; m_pub_sat = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic publish_run();
        for (int k = 0; k < 10; k++) begin
            m_pub[k] = m_run[k];
            m_run[k] = 0;
        end
        m_pub_sat = m_run_sat;
        m_run_sat = 0;
        m_valid   = 1;
    endtask

    task automatic model_step(input bit v, input int c, input longint p, input bit l, input bit a);
        longint s;
        if (m_parked) begin
            if (a) begin
                publish_run();
                m_parked = 0;
            end
        end else if (v) begin
            if (c <= 9) begin
                s = m_run[c] + p;
                if (s > SMAX) begin s = SMAX; m_run_sat = 1; end
                if (s < SMIN) begin s = SMIN; m_run_sat = 1; end
                m_run[c] = s;
            end else begin
                m_err = 1;
            end
            if (l) begin
                if (!m_valid || a) publish_run();
                else m_parked = 1;
            end else if (m_valid && a) begin
                m_valid = 0;
            end
        end else if (m_valid && a) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("InReady", longint'(InReady), longint'(!m_in_reset && !m_parked));
        chk("NumValid", longint'(NumValid), longint'(m_valid));
        chk("SatFlag", longint'(SatFlag), longint'(m_pub_sat));
        chk("ClassErr", longint'(ClassErr), longint'(m_err));
        for (int k = 0; k < 10; k++)
            chk($sformatf("score%0d", k), score(k), m_pub[k]);
    endtask

    task automatic cycle(input bit v, input int c, input longint p, input bit l, input bit a);
        logic [63:0] pw;
        pw      = 64'(p);
        InValid = v;
        InClass = 4'(c);
        InProd  = pw[PS-1:0];
        InLast  = l;
        NumAck  = a;
        @(posedge Clock);
        model_step(v, c, p, l, a);
        #1;
        compare_all();
        InValid = 0; InLast = 0; NumAck = 0;
    endtask

    task automatic do_reset();
        GlobalReset_n = 0;
        m_in_reset = 1;
        model_reset();
        #1;
        compare_all();
        @(posedge Clock);
        #1;
        compare_all();
        GlobalReset_n = 1;
        m_in_reset = 0;
        #1;
        compare_all();
    endtask

    initial begin
        InValid = 0; InClass = 0; InProd = 0; InLast = 0; NumAck = 0;
        GlobalReset_n = 0;
        m_in_reset = 1;
        model_reset();
        @(posedge Clock);
        #1;
        do_reset();

        // Basic sample.
        cycle(1, 3, 100, 0, 0);
        cycle(1, 3, -40, 0, 0);
        cycle(1, 7, 5, 1, 0);
        chk("t1_valid", longint'(NumValid), 1);
        chk("t1_score3", score(3), 60);
        chk("t1_score7", score(7), 5);
        chk("t1_score0", score(0), 0);
        chk("t1_sat", longint'(SatFlag), 0);

        // Positive then negative saturation.
        for (int i = 0; i < 1099; i++) cycle(1, 0, 32767, 0, 0);
        cycle(1, 0, 32767, 1, 1);
        chk("satp_score0", score(0), 33554431);
        chk("satp_flag", longint'(SatFlag), 1);
        for (int i = 0; i < 1099; i++) cycle(1, 0, -32768, 0, 0);
        cycle(1, 0, -32768, 1, 1);
        chk("satn_score0", score(0), -33554432);
        chk("satn_flag", longint'(SatFlag), 1);

        // Hold A, park B behind it, then release.
        cycle(0, 0, 0, 0, 1);
        cycle(1, 2, 7, 1, 0);
        cycle(1, 4, 3, 0, 0);
        cycle(1, 4, 3, 1, 0);
        chk("hold_ready", longint'(InReady), 0);
        chk("hold_scoreA", score(2), 7);
        cycle(0, 0, 0, 0, 0);
        chk("hold_still", score(2), 7);
        cycle(0, 0, 0, 0, 1);
        chk("rel_score4", score(4), 6);
        chk("rel_score2", score(2), 0);
        chk("rel_valid", longint'(NumValid), 1);
        chk("rel_ready", longint'(InReady), 1);
        cycle(0, 0, 0, 0, 1);

        // Out-of-range class ends the sample with nothing accumulated.
        cycle(1, 12, 9, 1, 1);
        chk("cerr_flag", longint'(ClassErr), 1);
        chk("cerr_valid", longint'(NumValid), 1);
        chk("cerr_score9", score(9), 0);

        // Back-to-back 3-beat samples acked on each last beat.
        for (int s = 0; s < 8; s++) begin
            cycle(1, s, 10 * s + 1, 0, 0);
            chk("b2b_ready", longint'(InReady), 1);
            cycle(1, s, 2, 0, 0);
            cycle(1, 9 - s, -7, 1, 1);
            chk("b2b_ready_l", longint'(InReady), 1);
            chk("b2b_valid", longint'(NumValid), 1);
            chk("b2b_score", score(s), longint'(10 * s + 3));
        end
        chk("cerr_sticky", longint'(ClassErr), 1);

        // Reset mid-sample and during WAIT.
        cycle(1, 1, 5, 0, 1);
        do_reset();
        chk("rst_num", longint'(Num == '0), 1);
        cycle(1, 5, 11, 1, 0);
        cycle(1, 6, 1, 0, 0);
        cycle(1, 6, 1, 1, 0);
        chk("rst_wait_ready", longint'(InReady), 0);
        do_reset();
        chk("rst2_valid", longint'(NumValid), 0);
        chk("rst2_err", longint'(ClassErr), 0);
        cycle(1, 1, 1, 1, 0);
        chk("fresh_score1", score(1), 1);
        chk("fresh_score6", score(6), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int     c;
            longint p;
            c = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            p = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                            : longint'($urandom_range(0, 65535)) - 32768;
            cycle(($urandom_range(0, 3) != 0), c, p, ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
